// File: rtl/mem_read_arbiter_if.sv
// rtl/mem_read_arbiter_if.sv - client AR/R and shared AXI read signal bundle for mem_read_arbiter
// master: arbiter view; slave: clients plus interconnect view.
interface mem_read_arbiter_if #(
  parameter int N_PORTS    = 2,
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8
);
  logic [N_PORTS-1:0]            s_arvalid;
  logic [N_PORTS-1:0]            s_arready;
  logic [N_PORTS*AXI_ADDR_W-1:0] s_araddr;
  logic [N_PORTS*8-1:0]          s_arlen;
  logic [N_PORTS*3-1:0]          s_arsize;
  logic [N_PORTS*2-1:0]          s_arburst;
  logic [N_PORTS-1:0]            s_rvalid;
  logic [N_PORTS-1:0]            s_rready;
  logic [AXI_DATA_W-1:0]         s_rdata;
  logic [1:0]                    s_rresp;
  logic                          s_rlast;

  logic                          m_arvalid;
  logic                          m_arready;
  logic [AXI_ID_W-1:0]           m_arid;
  logic [AXI_ADDR_W-1:0]         m_araddr;
  logic [7:0]                    m_arlen;
  logic [2:0]                    m_arsize;
  logic [1:0]                    m_arburst;
  logic [3:0]                    m_arregion;
  logic [3:0]                    m_arcache;
  logic [3:0]                    m_arqos;
  logic [2:0]                    m_arprot;
  logic                          m_rvalid;
  logic                          m_rready;
  logic [AXI_ID_W-1:0]           m_rid;
  logic [AXI_DATA_W-1:0]         m_rdata;
  logic [1:0]                    m_rresp;
  logic                          m_rlast;

  modport master (
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    output m_arregion, m_arcache, m_arqos, m_arprot, m_rready
  );

  modport slave (
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    input  m_arregion, m_arcache, m_arqos, m_arprot, m_rready
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin AR arbiter with in-order R steering for N_PORTS readers
// Optional R ID / empty-return checker: define MEM_READ_ARB_ID_CHECK_EN.
module mem_read_arbiter #(
  parameter int N_PORTS         = 2,
  parameter int AXI_DATA_W      = 128,
  parameter int AXI_ADDR_W      = 16,
  parameter int AXI_ID_W        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_read_arbiter_if.master  bus,
  output logic                err
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;

  logic [IDX_W-1:0]      fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q;

  logic                  found, push, pop, empty, rready;
  logic [IDX_W-1:0]      winner, head;
  logic [N_PORTS-1:0]    arready, rvalid;

  always_comb begin
    int j;
    found  = 1'b0;
    winner = '0;
    j      = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!found && bus.s_arvalid[IDX_W'(j)]) begin
        found  = 1'b1;
        winner = IDX_W'(j);
      end
    end
  end

  // s_arready is gated by rst so nothing handshakes while reset is held.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    arready  = '0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst && found && (count_q < (PTR_W+1)'(MAX_OUTSTANDING))) begin
          arready[winner] = 1'b1;
          idx_d    = winner;
          addr_d   = bus.s_araddr[winner*AXI_ADDR_W +: AXI_ADDR_W];
          len_d    = bus.s_arlen[winner*8 +: 8];
          size_d   = bus.s_arsize[winner*3 +: 3];
          burst_d  = bus.s_arburst[winner*2 +: 2];
          rr_ptr_d = (winner == IDX_W'(N_PORTS-1)) ? '0 : winner + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_arready) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    rvalid = '0;
    rready = 1'b0;
    if (!empty) begin
      rvalid[head] = bus.m_rvalid;
      rready       = bus.s_rready[head];
    end
  end

  assign pop = bus.m_rvalid & rready & bus.m_rlast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= idx_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    bus.m_arid             = '0;
    bus.m_arid[IDX_W-1:0]  = idx_q;
  end

  assign bus.m_arvalid  = (state_q == ISSUE);
  assign bus.m_araddr   = addr_q;
  assign bus.m_arlen    = len_q;
  assign bus.m_arsize   = size_q;
  assign bus.m_arburst  = burst_q;
  assign bus.m_arregion = 4'h0;
  assign bus.m_arcache  = 4'h0;
  assign bus.m_arqos    = 4'h0;
  assign bus.m_arprot   = 3'h0;
  assign bus.s_arready  = arready;
  assign bus.s_rvalid   = rvalid;
  assign bus.m_rready   = rready;
  assign bus.s_rdata    = bus.m_rdata;
  assign bus.s_rresp    = bus.m_rresp;
  assign bus.s_rlast    = bus.m_rlast;

  logic unused_rid;
  assign unused_rid = ^bus.m_rid;

`ifdef MEM_READ_ARB_ID_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((bus.m_rvalid && empty) ||
                 (bus.m_rvalid && rready && (bus.m_rid[IDX_W-1:0] != head))) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - self-checking bench for mem_read_arbiter
// Cycle table for arbitration/FIFO behaviour, then hand sequences for reset, single burst and checker.
module tb_mem_read_arbiter;
  localparam int NP = 2;
  localparam int DW = 128;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MO = 4;
`ifdef MEM_READ_ARB_ID_CHECK_EN
  localparam logic ID_CHECK = 1'b1;
`else
  localparam logic ID_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_read_arbiter_if #(.N_PORTS(NP), .AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ID_W(IW)) bus ();

  mem_read_arbiter #(
    .N_PORTS(NP), .AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ID_W(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master),
    .err(err)
  );

  typedef struct {
    logic [1:0]  arv;
    logic        mar;
    logic        rv;
    logic        rl;
    logic [1:0]  rrdy;
    logic [7:0]  rid;
    logic [1:0]  e_sar;
    logic        e_mav;
    logic        e_mid;
    logic [15:0] e_addr;
    logic [1:0]  e_srv;
    logic        e_mrr;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] arv, input logic mar, input logic rv, input logic rl,
                     input logic [1:0] rrdy, input logic [7:0] rid, input logic [1:0] sar,
                     input logic mav, input logic mid, input logic [15:0] addr,
                     input logic [1:0] srv, input logic mrr);
    vec_t v;
    v.arv = arv; v.mar = mar; v.rv = rv; v.rl = rl; v.rrdy = rrdy; v.rid = rid;
    v.e_sar = sar; v.e_mav = mav; v.e_mid = mid; v.e_addr = addr; v.e_srv = srv; v.e_mrr = mrr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [1:0] arv, input logic mar, input logic rv, input logic rl,
                       input logic [1:0] rrdy, input logic [7:0] rid, input logic [127:0] rdata);
    bus.s_arvalid = arv;
    bus.m_arready = mar;
    bus.m_rvalid  = rv;
    bus.m_rlast   = rl;
    bus.s_rready  = rrdy;
    bus.m_rid     = rid;
    bus.m_rdata   = rdata;
  endtask

  initial begin
    logic [127:0] rd;
    bus.s_araddr  = {16'h0200, 16'h0100};
    bus.s_arlen   = {8'd0, 8'd1};
    bus.s_arsize  = {3'd4, 3'd4};
    bus.s_arburst = {2'd1, 2'd1};
    bus.m_rresp   = 2'b00;
    drive(2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 8'd0, '0);

    //   arv    mar   rv    rl    rrdy   rid     sar    mav   mid   addr      srv    mrr
    add(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    add(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b00, 1'b1, 1'b0, 16'h0100, 2'b00, 1'b0);
    add(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b00, 1'b1, 1'b0, 16'h0100, 2'b00, 1'b0);
    add(2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0,  2'b00, 1'b1, 1'b0, 16'h0100, 2'b00, 1'b0);
    add(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b10, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0,  2'b00, 1'b1, 1'b1, 16'h0200, 2'b00, 1'b0);
    add(2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    add(2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0,  2'b00, 1'b1, 1'b0, 16'h0100, 2'b00, 1'b0);
    add(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b10, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    add(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0,  2'b00, 1'b1, 1'b1, 16'h0200, 2'b00, 1'b0);
    // FIFO now holds 0,1,0,1: port 0 must stall until the first rlast
    add(2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
    add(2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1);
    add(2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0);
    add(2'b01, 1'b0, 1'b1, 1'b1, 2'b01, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1);
    add(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0,  2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);
    add(2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 8'd1,  2'b00, 1'b1, 1'b0, 16'h0100, 2'b10, 1'b1);
    add(2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1);
    add(2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 8'd1,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b1);
    add(2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1);
    add(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd0,  2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    check("rst s_arready", bus.s_arready, 2'b00);
    check("rst m_arvalid", bus.m_arvalid, 1'b0);
    check("rst s_rvalid", bus.s_rvalid, 2'b00);
    check("rst m_rready", bus.m_rready, 1'b0);
    check("rst m_araddr", bus.m_araddr, 16'h0000);
    check("rst err", err, 1'b0);

    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rd = {16{8'(8'h30 + i)}};
      drive(vq[i].arv, vq[i].mar, vq[i].rv, vq[i].rl, vq[i].rrdy, vq[i].rid, rd);
      #1;
      check($sformatf("v%0d s_arready", i), bus.s_arready, vq[i].e_sar);
      check($sformatf("v%0d m_arvalid", i), bus.m_arvalid, vq[i].e_mav);
      if (vq[i].e_mav) begin
        check($sformatf("v%0d m_arid", i), bus.m_arid, {7'd0, vq[i].e_mid});
        check($sformatf("v%0d m_araddr", i), bus.m_araddr, vq[i].e_addr);
      end
      check($sformatf("v%0d s_rvalid", i), bus.s_rvalid, vq[i].e_srv);
      check($sformatf("v%0d m_rready", i), bus.m_rready, vq[i].e_mrr);
      check($sformatf("v%0d s_rdata", i), bus.s_rdata, rd);
    end

    // Single two-beat burst from port 0 (rr_ptr currently points at port 1)
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    #1;
    check("single s_arready", bus.s_arready, 2'b01);
    check("single m_arvalid early", bus.m_arvalid, 1'b0);
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    #1;
    check("single m_arvalid", bus.m_arvalid, 1'b1);
    check("single m_arid", bus.m_arid, 8'd0);
    check("single m_araddr", bus.m_araddr, 16'h0100);
    check("single m_arlen", bus.m_arlen, 8'd1);
    check("single m_arsize", bus.m_arsize, 3'd4);
    check("single m_arburst", bus.m_arburst, 2'd1);
    check("single ar consts", {bus.m_arregion, bus.m_arcache, bus.m_arqos, bus.m_arprot}, 15'd0);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 8'd0, {16{8'hAA}});
    #1;
    check("beat A s_rvalid", bus.s_rvalid, 2'b01);
    check("beat A s_rdata", bus.s_rdata, {16{8'hAA}});
    check("beat A m_rready", bus.m_rready, 1'b1);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 8'd0, {16{8'hBB}});
    #1;
    check("beat B s_rvalid", bus.s_rvalid, 2'b01);
    check("beat B s_rdata", bus.s_rdata, {16{8'hBB}});
    check("beat B s_rlast", bus.s_rlast, 1'b1);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 8'd0, '0);
    #1;
    check("single empty m_rready", bus.m_rready, 1'b0);

    // Port 1 alone is granted twice in a row
    @(negedge clk);
    drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    #1;
    check("p1 first grant", bus.s_arready, 2'b10);
    @(negedge clk);
    drive(2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    #1;
    check("p1 first issue id", bus.m_arid, 8'd1);
    @(negedge clk);
    drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    #1;
    check("p1 second grant", bus.s_arready, 2'b10);
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    #1;
    check("p1 second issue id", bus.m_arid, 8'd1);

    // Wrong R ID against head 1: routing unchanged, err only with the checker
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 8'd0, {16{8'hCC}});
    #1;
    check("bad id s_rvalid", bus.s_rvalid, 2'b10);
    check("bad id m_rready", bus.m_rready, 1'b1);
    @(negedge clk);
    drive(2'b11, 1'b0, 1'b1, 1'b0, 2'b10, 8'd1, {16{8'hDD}});
    #1;
    check("bad id err", err, ID_CHECK);
    check("mid burst s_rvalid", bus.s_rvalid, 2'b10);

    // Asynchronous reset mid-burst, away from any clock edge
    #2;
    rst = 1'b0;
    #1;
    check("async rst s_rvalid", bus.s_rvalid, 2'b00);
    check("async rst m_rready", bus.m_rready, 1'b0);
    check("async rst s_arready", bus.s_arready, 2'b00);
    check("async rst m_araddr", bus.m_araddr, 16'h0000);
    check("async rst err", err, 1'b0);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, '0);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
